// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Byte-stream handshake feeding the instruction-memory loader.
//   A byte transfers on any rising edge where byte_valid && byte_ready.
//   Signals:
//     byte_valid  source -> loader  source presents a byte on byte_data
//     byte_data   source -> loader  stream byte (8 bits)
//     byte_ready  loader -> source  loader accepts a byte this cycle
//   Modports: master = byte source, slave = loader.
interface imem_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Program loader for the pipeline's 256-word instruction memory.
//   Receives a framed byte stream (length byte L, (L+1) big-endian 32-bit
//   words, XOR checksum byte), writes each word to consecutive word
//   addresses 0..L, and keeps the pipeline in reset until a frame has been
//   loaded with a matching checksum plus RST_HOLD further cycles.
//   Parameters:
//     ADDR_W    instruction-memory word-address width (only 8 is meaningful,
//               since the length header is a single byte)
//     RST_HOLD  cycles cpu_rst stays high after a good checksum (1..255)
//   Ports:
//     clk           system clock, rising edge
//     rst           asynchronous active-low reset
//     start         single-cycle load request (honoured in IDLE/DONE/ERR)
//     bus           byte-stream handshake (slave side)
//     imem_we       one-cycle write strobe per assembled word
//     imem_waddr    word address of the write
//     imem_wdata    instruction word of the write
//     cpu_rst       active-high reset to the pipeline
//     done          last load passed its checksum
//     error         last load failed its checksum
//     words_loaded  words written in the current or last load (0..256)
module imem_loader #(
  parameter int ADDR_W   = 8,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [8:0]        words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_HOLD,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_reg;
  logic              byte_ready_reg;
  logic              imem_we_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [31:0]       wdata_reg;
  logic              cpu_rst_reg;
  logic              done_reg;
  logic              error_reg;
  // Doubles as the write-address counter: the low ADDR_W bits are the next
  // word address, and the 9th bit lets it reach 256 after an L=255 frame.
  logic [8:0]        count_reg;
  logic [7:0]        len_reg;
  logic [7:0]        xor_reg;
  // Only the first three bytes of a word need storing; the fourth is
  // concatenated straight into the write data.
  logic [23:0]       word_reg;
  logic [1:0]        byte_idx_reg;
  logic [7:0]        hold_reg;

  logic xfer;
  assign xfer = bus.byte_valid && byte_ready_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      byte_ready_reg <= 1'b0;
      imem_we_reg    <= 1'b0;
      waddr_reg      <= '0;
      wdata_reg      <= '0;
      cpu_rst_reg    <= 1'b1;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      count_reg      <= '0;
      len_reg        <= '0;
      xor_reg        <= '0;
      word_reg       <= '0;
      byte_idx_reg   <= '0;
      hold_reg       <= '0;
    end else begin
      imem_we_reg <= 1'b0;

      // The counter advances in the cycle the strobe is high, so the address
      // used for a write is the pre-increment value. The next 4th byte is at
      // least 4 cycles away, so the counter is always current when sampled.
      if (imem_we_reg) begin
        count_reg <= count_reg + 9'd1;
      end

      case (state_reg)
        S_IDLE: begin
          cpu_rst_reg <= 1'b1;
          if (start) begin
            state_reg      <= S_LEN;
            byte_ready_reg <= 1'b1;
            count_reg      <= '0;
            xor_reg        <= '0;
            byte_idx_reg   <= '0;
          end
        end

        S_LEN: begin
          if (xfer) begin
            len_reg   <= bus.byte_data;
            xor_reg   <= bus.byte_data;
            state_reg <= S_DATA;
          end
        end

        S_DATA: begin
          if (xfer) begin
            xor_reg      <= xor_reg ^ bus.byte_data;
            word_reg     <= {word_reg[15:0], bus.byte_data};
            byte_idx_reg <= byte_idx_reg + 2'd1;
            if (byte_idx_reg == 2'd3) begin
              imem_we_reg <= 1'b1;
              waddr_reg   <= count_reg[ADDR_W-1:0];
              wdata_reg   <= {word_reg, bus.byte_data};
              // byte_ready stays high, so the checksum may follow at once.
              if (count_reg[7:0] == len_reg) begin
                state_reg <= S_CHK;
              end
            end
          end
        end

        S_CHK: begin
          if (xfer) begin
            byte_ready_reg <= 1'b0;
            if (bus.byte_data == xor_reg) begin
              state_reg <= S_HOLD;
              hold_reg  <= 8'(RST_HOLD);
            end else begin
              state_reg <= S_ERR;
            end
          end
        end

        S_HOLD: begin
          // Counts RST_HOLD..0, so DONE is entered RST_HOLD+1 edges after
          // the checksum edge.
          if (hold_reg == 8'd0) begin
            state_reg   <= S_DONE;
            done_reg    <= 1'b1;
            cpu_rst_reg <= 1'b0;
          end else begin
            hold_reg <= hold_reg - 8'd1;
          end
        end

        S_DONE, S_ERR: begin
          if (state_reg == S_ERR) begin
            error_reg <= 1'b1;
          end
          if (start) begin
            state_reg      <= S_LEN;
            byte_ready_reg <= 1'b1;
            cpu_rst_reg    <= 1'b1;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            count_reg      <= '0;
            xor_reg        <= '0;
            byte_idx_reg   <= '0;
          end
        end

        default: begin
          state_reg      <= S_IDLE;
          byte_ready_reg <= 1'b0;
          cpu_rst_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_reg;
  assign imem_we        = imem_we_reg;
  assign imem_waddr     = waddr_reg;
  assign imem_wdata     = wdata_reg;
  assign cpu_rst        = cpu_rst_reg;
  assign done           = done_reg;
  assign error          = error_reg;
  assign words_loaded   = count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Self-checking bench for imem_loader. Expected memory writes are pushed
//   to a scoreboard queue as each word's last byte is driven and popped by a
//   monitor whenever imem_we is seen.
module tb_imem_loader;
  localparam int HOLD = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  imem_loader_if bus ();

  imem_loader #(
    .ADDR_W   (8),
    .RST_HOLD (HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;

  logic [39:0] sb_q[$];
  logic [31:0] frame_words [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        logic [39:0] e;
        e = sb_q.pop_front();
        chk("we_addr", {24'd0, imem_waddr}, {24'd0, e[39:32]});
        chk("we_data", imem_wdata, e[31:0]);
        $display("write addr=%0d data=0x%08h", imem_waddr, imem_wdata);
      end
    end
  end

  always @(posedge clk) begin
    if (rst && bus.byte_valid && bus.byte_ready) xfers++;
  end

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    chk({pfx, "_ready"}, {31'd0, bus.byte_ready}, 32'd0);
    chk({pfx, "_we"}, {31'd0, imem_we}, 32'd0);
    chk({pfx, "_done"}, {31'd0, done}, 32'd0);
    chk({pfx, "_error"}, {31'd0, error}, 32'd0);
    chk({pfx, "_waddr"}, {24'd0, imem_waddr}, 32'd0);
    chk({pfx, "_wdata"}, imem_wdata, 32'd0);
    chk({pfx, "_words"}, {23'd0, words_loaded}, 32'd0);
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic send_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ready", {31'd0, bus.byte_ready}, 32'd1);
    chk("start_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("start_done", {31'd0, done}, 32'd0);
    chk("start_error", {31'd0, error}, 32'd0);
    chk("start_words", {23'd0, words_loaded}, 32'd0);
  endtask

  // Presents one byte until it is taken; returns at the falling edge right
  // after the accepting rising edge, optionally idling one more cycle.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic send_frame(input int len, input int bad, input bit gap, input int start_pos);
    logic [7:0] cs;
    logic [7:0] b;
    cs = len[7:0];
    send_start();
    send_byte(len[7:0], gap);
    for (int w = 0; w <= len; w++) begin
      for (int k = 0; k < 4; k++) begin
        b  = frame_words[w][31-8*k -: 8];
        cs = cs ^ b;
        if (k == 3) sb_q.push_back({w[7:0], frame_words[w]});
        if (w * 4 + k == start_pos) start = 1'b1;
        send_byte(b, gap);
        start = 1'b0;
      end
    end
    cs = cs + bad[7:0];
    send_byte(cs, 1'b0);
    $display("frame len=%0d checksum=0x%02h sent", len + 1, cs);
  endtask

  // Entered at the falling edge after the checksum edge N.
  task automatic expect_done(input string pfx);
    for (int k = 0; k <= HOLD; k++) begin
      chk({pfx, "_hold_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
      chk({pfx, "_hold_done"}, {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    chk({pfx, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd0);
    chk({pfx, "_done"}, {31'd0, done}, 32'd1);
    chk({pfx, "_error"}, {31'd0, error}, 32'd0);
    chk({pfx, "_sb_empty"}, sb_q.size(), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("idle");

    // L=0 single word, checksum 0x2D.
    frame_words[0] = 32'h2008_0005;
    send_frame(0, 0, 1'b0, -1);
    expect_done("l0");
    chk("l0_words", {23'd0, words_loaded}, 32'd1);

    // L=2, source valid every other cycle, stray start mid-DATA.
    frame_words[0] = 32'h1234_5678;
    frame_words[1] = 32'h9ABC_DEF0;
    frame_words[2] = 32'h0F1E_2D3C;
    send_frame(2, 0, 1'b1, 5);
    expect_done("l2");
    chk("l2_words", {23'd0, words_loaded}, 32'd3);

    // Same frame with checksum off by one.
    send_frame(2, 1, 1'b0, -1);
    @(negedge clk);
    chk("bad_error", {31'd0, error}, 32'd1);
    chk("bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("bad_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    chk("bad_error_held", {31'd0, error}, 32'd1);
    chk("bad_words", {23'd0, words_loaded}, 32'd3);

    // Restart clears error and a correct frame completes.
    send_frame(2, 0, 1'b0, -1);
    expect_done("retry");

    // Full 256-word frame, source always valid.
    for (int i = 0; i < 256; i++) frame_words[i] = $urandom;
    xfers = 0;
    send_frame(255, 0, 1'b0, -1);
    expect_done("l255");
    chk("l255_words", {23'd0, words_loaded}, 32'd256);
    chk("l255_xfers", xfers, 32'd1026);

    // Reset mid-DATA: one word written, then two bytes of the next.
    for (int i = 0; i < 4; i++) frame_words[i] = 32'hA0B0_C0D0 + i;
    send_start();
    send_byte(8'd3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) sb_q.push_back({8'd0, frame_words[0]});
      send_byte(frame_words[0][31-8*k -: 8], 1'b0);
    end
    send_byte(8'hA0, 1'b0);
    send_byte(8'hB0, 1'b0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hC0;
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check_reset_vals("after_rst");
    chk("after_rst_sb", sb_q.size(), 32'd0);
    bus.byte_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes into the pipeline's 256-word instruction memory, the write-side counterpart of the fetch port the IF stage reads through `pc[9:2]`. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes them to consecutive word addresses, verifies an XOR checksum, and holds the pipeline in reset until a load completes cleanly.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width; the length header is one byte, so only 8 is supported.
- `RST_HOLD`, default 4: cycles `cpu_rst` stays high after a good checksum before release; legal range 1..255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous and active-low.
- `start`  in  1  single-cycle request to begin a load.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_waddr`  out  ADDR_W  word address for the write.
- `imem_wdata`  out  32  instruction word for the write.
- `cpu_rst`  out  1  active-high reset to the pipeline.
- `done`  out  1  last load passed its checksum.
- `error`  out  1  last load failed its checksum.
- `words_loaded`  out  9  words written in the current or last load.

## Operation
- Frame format:
  - L: one length byte giving word count minus 1, so 1..256 words.
  - Data: (L+1) words of 4 bytes each, most significant byte first.
  - C: one checksum byte equal to the XOR of L and every data byte.
- A byte transfers on any cycle where `byte_valid && byte_ready` at the rising edge.
- `byte_ready` is high only in LEN, DATA and CHK.
- State IDLE:
  - `cpu_rst`=1.
  - `start` moves to LEN and clears `words_loaded`, the running XOR, the byte index and the address counter.
- State LEN:
  - On transfer, latch L and seed the XOR with L.
  - Move to DATA.
- State DATA:
  - Shift each byte into the word register and XOR it into the running checksum.
  - On the 4th byte, register address/data and pulse `imem_we` for exactly the next cycle.
  - Then increment the address counter and `words_loaded`.
  - `byte_ready` stays high through the write, so there is no stall and back-to-back words are legal.
  - After the 4th byte of word L, move to CHK.
- State CHK:
  - On transfer, compare the byte to the running XOR.
  - Equal: move to HOLD and load the hold counter with `RST_HOLD`.
  - Unequal: move to ERR.
- State HOLD:
  - `cpu_rst`=1 while the counter decrements.
  - At zero, move to DONE.
- State DONE: `done`=1, `cpu_rst`=0, so the pipeline runs.
- State ERR: `error`=1, `cpu_rst`=1.
- `start` is ignored in LEN, DATA, CHK and HOLD.
- `start` in DONE or ERR re-enters LEN on the next edge. On that edge:
  - `cpu_rst` reasserts.
  - `done` and `error` clear.
  - The counters clear.
- Address rules:
  - `imem_waddr` runs 0..L and never wraps within a frame; L=255 writes address 255 last.
  - `words_loaded` saturates at 256 by construction, hence its 9-bit width.
- Bytes presented while `byte_ready`=0 are not consumed; the source holds them.

## Timing
- Reset values:
  - `cpu_rst`=1.
  - `byte_ready`, `imem_we`, `done` and `error` = 0.
  - `imem_waddr`=0, `imem_wdata`=0, `words_loaded`=0.
  - State = IDLE.
- Reset assertion takes effect immediately, even mid-frame. A partial load leaves already-written words in memory; no rollback.
- `start` to `byte_ready` high: 1 cycle.
- 4th data byte accepted at edge N:
  - `imem_we`=1, address and data valid during cycle N+1.
  - `words_loaded` updates at edge N+1.
- Checksum accepted at edge N:
  - `cpu_rst` falls at edge N+`RST_HOLD`+1, when `done` rises.
  - If the checksum is wrong, `error` rises at edge N+1.
- A full frame with a continuously valid source takes 4(L+1)+2 transfer cycles.
- A write pulse coincident with entry to CHK completes normally; a checksum byte in the very next cycle is accepted.

## Test plan
- Reset mid-DATA, then release:
  - Outputs must equal their reset values.
  - `cpu_rst`=1.
  - No further `imem_we`.
- Frame L=0, data 20080005, C=0x2D:
  - One `imem_we` with addr 0 and data 0x20080005.
  - `words_loaded`=1.
  - `cpu_rst` falls 5 cycles after C; `done`=1.
- Frame L=2 with three words, source `byte_valid` toggling every other cycle:
  - Writes at addr 0, 1, 2 with correct big-endian data.
  - No byte is lost or duplicated.
- Same frame with C off by 1:
  - `error`=1 one cycle after C.
  - `cpu_rst` stays 1; `done`=0.
  - `start` then clears `error`, and a correct frame completes.
- L=255 frame, source always valid:
  - 256 writes, last at addr 255 with no wrap.
  - `words_loaded`=256.
  - Total 1026 transfers.
- `start` pulsed mid-DATA: no effect on state, address or counters.
